// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: sequencer state encoding and default iteration geometry,
// used by the sequencer, the datapath and the arctan ROM.
package cordic_pkg;

    localparam int CORDIC_N_ITER = 16;
    localparam int CORDIC_IW     = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_DONE      = 3'd4
    } cordic_state_e;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a debounced step button: one registered step_req pulse
// per press, independent of how long the button is held.
module btn_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step_req
);

    logic r_b1;
    logic r_b2;
    logic r_step_req;

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b1       <= 1'b0;
            r_b2       <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_b1       <= btn;
            r_b2       <= r_b1;
            r_step_req <= r_b1 & ~r_b2;
        end
    end

    assign step_req = r_step_req;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// CORDIC iteration sequencer: loads the datapath, then walks the arctan table index
// either free-running or one step per button press, with abort and done signalling.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = CORDIC_N_ITER,
    parameter int IW     = CORDIC_IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step_mode,
    input  logic          btn,
    input  logic          abort,
    output logic          ld,
    output logic          iter_en,
    output logic [IW-1:0] iter,
    output logic [IW:0]   iter_cnt,
    output logic          busy,
    output logic          done
);

    localparam int            CW        = IW + 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(N_ITER - 1);
    localparam logic [IW:0]   MAX_CNT   = CW'(N_ITER);

    cordic_state_e r_state;
    logic [IW-1:0] r_iter;
    logic [IW:0]   r_iter_cnt;
    logic          r_step_mode;
    logic          w_step_req;
    logic          w_step;
    logic          w_last;

    btn_edge_det u_btn_edge_det (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .step_req (w_step_req)
    );

    // A step happens every RUN cycle, or in WAIT_STEP only on a button pulse;
    // pulses arriving in any other state simply vanish.
    assign w_step = (r_state == ST_RUN) || ((r_state == ST_WAIT_STEP) && w_step_req);
    assign w_last = (r_iter == LAST_ITER);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_iter      <= '0;
            r_iter_cnt  <= '0;
            r_step_mode <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_iter <= '0;
                    if (start && !abort) begin
                        r_state     <= ST_LOAD;
                        r_step_mode <= step_mode;
                        r_iter_cnt  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort)            r_state <= ST_IDLE;
                    else if (r_step_mode) r_state <= ST_WAIT_STEP;
                    else                  r_state <= ST_RUN;
                end
                ST_RUN, ST_WAIT_STEP: begin
                    // The rotation performed this cycle still counts when aborting.
                    if (w_step && (r_iter_cnt != MAX_CNT))
                        r_iter_cnt <= r_iter_cnt + 1'b1;
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_iter  <= '0;
                    end else if (w_step) begin
                        if (w_last) r_state <= ST_DONE;
                        else        r_iter  <= r_iter + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_iter  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_iter  <= '0;
                end
            endcase
        end
    end

    assign ld       = (r_state == ST_LOAD);
    assign iter_en  = w_step;
    assign iter     = r_iter;
    assign iter_cnt = r_iter_cnt;
    assign busy     = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_WAIT_STEP);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: free-run timing, single-step, abort, mid-op reset
// and back-to-back starts, with hand-derived expected output vectors.
module tb_cordic_seq_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset, start, step_mode, btn, abort;
    logic          ld, iter_en, busy, done;
    logic [IW-1:0] iter;
    logic [IW:0]   iter_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // press bookkeeping
    int en_cnt, last_en_cyc, last_en_iter, done_cyc, done_cnt, busy_low;

    // packed vector layout: {ld, iter_en, iter[3:0], iter_cnt[4:0], busy, done}
    localparam logic [12:0] ALL     = 13'h1fff;
    localparam logic [12:0] NO_ITER = 13'b1_1_0000_11111_1_1;

    always #5 clk = ~clk;

    cordic_seq_ctrl #(.N_ITER(N), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_mode (step_mode),
        .btn       (btn),
        .abort     (abort),
        .ld        (ld),
        .iter_en   (iter_en),
        .iter      (iter),
        .iter_cnt  (iter_cnt),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [12:0] obs();
        return {ld, iter_en, iter, iter_cnt, busy, done};
    endfunction

    function automatic logic [12:0] ev(input logic l, input logic e, input logic [3:0] it,
                                       input logic [4:0] c, input logic b, input logic d);
        return {l, e, it, c, b, d};
    endfunction

    // Expected outputs k cycles after a free-run start was sampled (start in cycle 0).
    function automatic logic [12:0] free_exp(input int k);
        if (k == 1)                return ev(1'b1, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        else if (k >= 2 && k <= 17) return ev(1'b0, 1'b1, 4'(k - 2), 5'(k - 2), 1'b1, 1'b0);
        else if (k == 18)          return ev(1'b0, 1'b0, 4'd0, 5'd16, 1'b0, 1'b1);
        else                       return ev(1'b0, 1'b0, 4'd0, 5'd16, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] free_mask(input int k);
        return (k == 18) ? NO_ITER : ALL;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic press(input int hold, input int gap);
        btn = 1'b1;
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) btn = 1'b0;
            tick();
            if (iter_en) begin
                en_cnt++;
                last_en_cyc  = cyc;
                last_en_iter = int'(iter);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic clear_press();
        en_cnt = 0; last_en_cyc = -1; last_en_iter = -1;
        done_cyc = -1; done_cnt = 0; busy_low = 0;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        reset = 1'b1; start = 1'b0; step_mode = 1'b0; btn = 1'b0; abort = 1'b0;
        tick();
        tick();
        e = '0;
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", obs(), e);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs(), e);
        end
    endtask

    task automatic test_free_run();
        start = 1'b1; step_mode = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            start = 1'b0;
            n_vec++;
            if ((obs() & free_mask(k)) !== (free_exp(k) & free_mask(k))) begin
                n_err++;
                $display("FAIL free_run k=%0d got=%b exp=%b", k, obs(), free_exp(k));
            end
        end
    endtask

    task automatic test_step_mode();
        logic [12:0] e;
        start = 1'b1; step_mode = 1'b1;
        tick();
        start = 1'b0; step_mode = 1'b0;
        e = ev(1'b1, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL step_load got=%b exp=%b", obs(), e);
        end
        tick();
        e = ev(1'b0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL step_wait got=%b exp=%b", obs(), e);
        end
        clear_press();
        for (int p = 0; p < 3; p++) press(10, 4);
        n_vec++;
        if (en_cnt !== 3) begin
            n_err++;
            $display("FAIL step_en_count got=%0d exp=3", en_cnt);
        end
        n_vec++;
        if (busy_low !== 0) begin
            n_err++;
            $display("FAIL step_busy_drop got=%0d exp=0", busy_low);
        end
        e = ev(1'b0, 1'b0, 4'd3, 5'd3, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL step_after3 got=%b exp=%b", obs(), e);
        end
    endtask

    task automatic test_step_complete();
        logic [12:0] e;
        clear_press();
        for (int p = 0; p < 13; p++) press(3, 4);
        n_vec++;
        if (en_cnt !== 13) begin
            n_err++;
            $display("FAIL complete_en_count got=%0d exp=13", en_cnt);
        end
        n_vec++;
        if (last_en_iter !== 15) begin
            n_err++;
            $display("FAIL complete_last_iter got=%0d exp=15", last_en_iter);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc !== last_en_cyc + 1) begin
            n_err++;
            $display("FAIL complete_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, last_en_cyc + 1);
        end
        e = ev(1'b0, 1'b0, 4'd0, 5'd16, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL complete_idle got=%b exp=%b", obs(), e);
        end
        clear_press();
        press(5, 4);
        n_vec++;
        if (en_cnt !== 0 || done_cnt !== 0) begin
            n_err++;
            $display("FAIL idle_press got=en%0d/done%0d exp=0/0", en_cnt, done_cnt);
        end
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL idle_press_state got=%b exp=%b", obs(), e);
        end
    endtask

    task automatic test_abort();
        logic [12:0] e;
        bit found;
        int dn;
        start = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (iter_en && iter == 4'd7) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_reach_iter7 got=timeout exp=iter7");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = ev(1'b0, 1'b0, 4'd0, 5'd8, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL abort_state got=%b exp=%b", obs(), e);
        end
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || iter_en) dn++;
        end
        n_vec++;
        if (dn !== 0 || iter_cnt !== 5'd8) begin
            n_err++;
            $display("FAIL abort_quiet got=act%0d/cnt%0d exp=0/8", dn, iter_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        start = 1'b1; step_mode = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clear_press();
        for (int p = 0; p < 5; p++) press(2, 4);
        n_vec++;
        if (iter_cnt !== 5'd5 || !busy) begin
            n_err++;
            $display("FAIL mid_pre_reset got=cnt%0d/busy%b exp=5/1", iter_cnt, busy);
        end
        reset = 1'b1; btn = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; btn = 1'b0; start = 1'b0; abort = 1'b0;
        e = '0;
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL mid_reset got=%b exp=%b", obs(), e);
        end
        tick();
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL mid_reset_idle got=%b exp=%b", obs(), e);
        end
        start = 1'b1; step_mode = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            start = 1'b0;
            n_vec++;
            if ((obs() & free_mask(k)) !== (free_exp(k) & free_mask(k))) begin
                n_err++;
                $display("FAIL restart k=%0d got=%b exp=%b", k, obs(), free_exp(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        start = 1'b1; step_mode = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_vec++;
            if ((obs() & free_mask(k)) !== (free_exp(k) & free_mask(k))) begin
                n_err++;
                $display("FAIL held_start k=%0d got=%b exp=%b", k, obs(), free_exp(k));
            end
        end
        tick();
        e = ev(1'b1, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL held_restart_ld got=%b exp=%b", obs(), e);
        end
        start = 1'b0; abort = 1'b1;
        tick();
        e = '0;
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL abort_in_load got=%b exp=%b", obs(), e);
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL start_abort_idle i=%0d got=%b exp=%b", i, obs(), e);
            end
        end
        start = 1'b0; abort = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_step_mode();
        test_step_complete();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
